vcve2_vlsu_seq: RTL and testbench
=================================

# vcve2_vlsu_seq

Vector load/store sequencer for the vector unit. It turns one vector memory command (base, stride, word count, direction) into a stream of 32-bit OBI-style transactions on one VRF data port. That port (vrf_data_*) feeds the data-memory switch. Load responses go back to the VRF write path tagged with an element index, and store data is taken from a VRF valid/ready stream.

## Interface
- MaxOutstanding, default 2: max granted-but-unanswered requests (1..7).
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  command strobe; sampled only in IDLE.
- is_store_i  in  1  1 = store, 0 = load; sampled with start_i.
- base_addr_i  in  32  first word address; sampled with start_i.
- stride_i  in  32  byte offset between elements; sampled with start_i.
- num_words_i  in  8  element count, 0 allowed; sampled with start_i.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at command completion.
- err_o  out  1  sticky OR of data_err_i over the command; cleared by accepted start_i.
- st_valid_i  in  1  store data valid.
- st_data_i  in  32  store data.
- st_ready_o  out  1  store word consumed (equals store grant).
- ld_valid_o  out  1  load data valid, no backpressure.
- ld_data_o  out  32  load data.
- ld_idx_o  out  8  element index of ld_data_o.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory grant.
- data_rvalid_i  in  1  response valid, in order.
- data_we_o  out  1  write enable.
- data_be_o  out  4  byte enables, constant 4'hF.
- data_addr_o  out  32  request address.
- data_wdata_o  out  32  write data.
- data_rdata_i  in  32  read data.
- data_err_i  in  1  response error, qualified by data_rvalid_i.

## Operation
- Registers:
  - state_q: IDLE, ISSUE, DRAIN.
  - addr_q (32b).
  - issued_q, rcvd_q (8b).
  - outst_q (3b).
  - store_q, num_q, stride_q.
  - err_q, done_q.
- IDLE:
  - start_i with num_words_i != 0: load the registers, clear err_q, set issued_q, rcvd_q and outst_q to 0, go to ISSUE.
  - start_i with num_words_i == 0: clear err_q, set done_q, stay in IDLE.
- ISSUE:
  - data_req_o = (outst_q < MaxOutstanding) && (!store_q || st_valid_i).
  - data_addr_o = addr_q; data_we_o = store_q; data_wdata_o = st_data_i.
  - Once data_req_o is high, address and we stay stable until grant (OBI). Upstream holds st_valid_i and st_data_i until st_ready_o.
  - Handshake = data_req_o && data_gnt_i. On handshake: addr_q += stride_q (mod 2^32), issued_q += 1, and st_ready_o = 1 if store.
  - Handshake on the last element (issued_q == num_q-1): go to DRAIN.
- DRAIN:
  - data_req_o = 0.
  - When outst_q == 0 and rcvd_q == num_q: go to IDLE and set done_q.
- Outstanding counter: +1 on handshake, −1 on data_rvalid_i, unchanged when both occur. data_rvalid_i with outst_q == 0 is ignored (no underflow, no ld_valid_o).
- Responses, on each counted data_rvalid_i:
  - rcvd_q += 1.
  - err_q |= data_err_i.
  - Loads only: ld_valid_o = 1, ld_data_o = data_rdata_i, ld_idx_o = rcvd_q (value before increment).
- Responses count in both ISSUE and DRAIN.
- start_i outside IDLE is ignored.
- Reset mid-command: everything returns to reset values immediately. Late rvalids are then ignored because outst_q = 0.

## Timing
- Reset values:
  - busy_o, done_o, err_o, st_ready_o, ld_valid_o, data_req_o, data_we_o = 0.
  - data_addr_o, data_wdata_o, ld_data_o, ld_idx_o = 0.
  - data_be_o = 4'hF.
- Request timing: the first data_req_o is high in the cycle after the accepted start_i; start-to-request latency is 1 cycle.
- Back-to-back grants give one element per cycle when MaxOutstanding ≥ memory latency + 1.
- Load data timing: ld_valid_o, ld_data_o and ld_idx_o are combinational from data_rvalid_i (0-cycle).
- done_o is registered. It is high in the cycle after the final rvalid, together with busy_o = 0; err_o is already final in that cycle.
- With num_words_i == 0, done_o is high in the cycle after start_i.
- A new start_i is accepted in the same cycle that done_o is high.

## Test plan
- Load, base 0x1000, stride 4, num 4, gnt always 1, rvalid 1 cycle after grant with rdata = addr:
  - Requests go to 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles.
  - ld_idx_o runs 0..3 with data 0x1000..0x100C.
  - done_o pulses once, 1 cycle after the 4th rvalid.
- Store, stride −8 (0xFFFFFFF8), base 0x4, num 3, st_valid_i toggling every other cycle:
  - Addresses are 0x4, 0xFFFFFFFC, 0xFFFFFFF4 (wrap).
  - data_we_o = 1, and st_ready_o pulses exactly 3 times.
- MaxOutstanding = 2, gnt held 1, rvalid withheld for 5 cycles:
  - data_req_o drops after 2 grants.
  - Issue resumes in the cycle after the first rvalid.
  - Grant and rvalid in the same cycle leave outst_q unchanged.
- gnt held low for 3 cycles during a request:
  - data_req_o and data_addr_o stay stable until the grant.
- data_err_i = 1 on element 1 of 3:
  - err_o goes high and stays high through done_o.
  - err_o clears on the next accepted start_i.
- num_words_i = 0: no data_req_o, done_o high one cycle later. Separately, assert rst_ni low mid-DRAIN, then send a stray rvalid: all outputs return to reset values and ld_valid_o stays 0.

Source files
------------

// File: rtl/vcve2_vlsu_seq_if.sv
// VRF data port of the vector load/store sequencer: OBI-style request/grant
// with in-order responses, feeding the data-memory switch.
interface vcve2_vlsu_seq_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/vcve2_vlsu_seq.sv
// Vector load/store sequencer: expands one strided vector memory command into
// a stream of 32-bit word transactions and tags load responses with their index.
module vcve2_vlsu_seq #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] stride_i,
  input  logic [7:0]  num_words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        st_valid_i,
  input  logic [31:0] st_data_i,
  output logic        st_ready_o,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic [7:0]  ld_idx_o,
  vcve2_vlsu_seq_if.master vrf_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [2:0] MaxOut = 3'(MaxOutstanding);

  state_e      state_q, state_d;
  logic [31:0] addr_q, stride_q;
  logic [7:0]  issued_q, rcvd_q, num_q, rcvd_d;
  logic [2:0]  outst_q, outst_d;
  logic        store_q, err_q, done_q;
  logic        start_ok, start_cmd, hs, rsp, last_hs;

  assign start_ok  = (state_q == IDLE) && start_i;
  assign start_cmd = start_ok && (num_words_i != 8'd0);
  assign hs        = vrf_data.data_req && vrf_data.data_gnt;
  assign last_hs   = hs && (issued_q == num_q - 8'd1);
  // Responses with nothing outstanding (e.g. after a mid-command reset) are dropped.
  assign rsp       = vrf_data.data_rvalid && (outst_q != 3'd0);
  assign rcvd_d    = rsp ? rcvd_q + 8'd1 : rcvd_q;

  always_comb begin
    outst_d = outst_q;
    if (hs && !rsp)      outst_d = outst_q + 3'd1;
    else if (!hs && rsp) outst_d = outst_q - 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Drain exit looks at next-cycle counts so done follows the final rvalid by one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_cmd) state_d = ISSUE;
      ISSUE:   if (last_hs) state_d = DRAIN;
      DRAIN:   if ((outst_d == 3'd0) && (rcvd_d == num_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vrf_data.data_req   = 1'b0;
    vrf_data.data_we    = 1'b0;
    vrf_data.data_be    = 4'hF;
    vrf_data.data_addr  = addr_q;
    vrf_data.data_wdata = 32'h0;
    busy_o              = (state_q != IDLE);
    if (state_q != IDLE) vrf_data.data_we = store_q;
    if (state_q == ISSUE) begin
      vrf_data.data_req = (outst_q < MaxOut) && (!store_q || st_valid_i);
      if (store_q) vrf_data.data_wdata = st_data_i;
    end
  end

  assign st_ready_o = hs && store_q;
  assign ld_valid_o = rsp && !store_q;
  assign ld_data_o  = ld_valid_o ? vrf_data.data_rdata : 32'h0;
  assign ld_idx_o   = ld_valid_o ? rcvd_q : 8'h0;
  assign done_o     = done_q;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= 32'h0;
      stride_q <= 32'h0;
      num_q    <= 8'h0;
      store_q  <= 1'b0;
      issued_q <= 8'h0;
      rcvd_q   <= 8'h0;
      outst_q  <= 3'h0;
    end else if (start_cmd) begin
      addr_q   <= base_addr_i;
      stride_q <= stride_i;
      num_q    <= num_words_i;
      store_q  <= is_store_i;
      issued_q <= 8'h0;
      rcvd_q   <= 8'h0;
      outst_q  <= 3'h0;
    end else begin
      if (hs) begin
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + 8'd1;
      end
      rcvd_q  <= rcvd_d;
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= ((state_q == DRAIN) && (state_d == IDLE)) ||
                (start_ok && (num_words_i == 8'd0));
      if (start_ok)                       err_q <= 1'b0;
      else if (rsp && vrf_data.data_err)  err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vcve2_vlsu_seq.sv
// Directed bench for vcve2_vlsu_seq with a cycle-stepped memory responder.
module tb_vcve2_vlsu_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i, is_store_i;
  logic [31:0] base_addr_i, stride_i;
  logic [7:0]  num_words_i;
  logic        busy_o, done_o, err_o;
  logic        st_valid_i, st_ready_o;
  logic [31:0] st_data_i;
  logic        ld_valid_o;
  logic [31:0] ld_data_o;
  logic [7:0]  ld_idx_o;

  always #5 clk_i = ~clk_i;

  vcve2_vlsu_seq_if vrf_data();

  vcve2_vlsu_seq #(.MaxOutstanding(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .is_store_i  (is_store_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .num_words_i (num_words_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .st_valid_i  (st_valid_i),
    .st_data_i   (st_data_i),
    .st_ready_o  (st_ready_o),
    .ld_valid_o  (ld_valid_o),
    .ld_data_o   (ld_data_o),
    .ld_idx_o    (ld_idx_o),
    .vrf_data    (vrf_data)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  rsp_t        pend[$];
  int          cyc = 0;
  int          gnt_low_until = 0, rv_block_until = 0, err_idx = -1, rsp_cnt = 0;
  int          st_cnt = 0, st_ready_cnt = 0;
  bit          st_mode = 0, st_hold = 0, start_req = 0, stray_rv = 0;
  logic [31:0] hs_addr[$], hs_cyc[$], hs_we[$], hs_wdata[$];
  logic [31:0] ld_data_q[$], ld_idx_q[$], rv_cyc[$], done_cyc[$];
  logic        req_at[int];
  logic [31:0] addr_at[int];
  logic        err_at[int];
  logic        busy_at[int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    hs_addr.delete(); hs_cyc.delete(); hs_we.delete(); hs_wdata.delete();
    ld_data_q.delete(); ld_idx_q.delete(); rv_cyc.delete(); done_cyc.delete();
    req_at.delete(); addr_at.delete(); err_at.delete(); busy_at.delete();
    rsp_cnt = 0; st_cnt = 0; st_ready_cnt = 0; st_hold = 0;
  endtask

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step();
    @(negedge clk_i);
    cyc++;
    start_i    = start_req;
    start_req  = 0;
    st_valid_i = st_mode && (st_hold || (cyc % 2 == 0));
    st_data_i  = st_valid_i ? 32'hD000_0000 + 32'(st_cnt) : 32'h0;
    vrf_data.data_gnt    = (cyc >= gnt_low_until);
    vrf_data.data_rvalid = 1'b0;
    vrf_data.data_rdata  = 32'h0;
    vrf_data.data_err    = 1'b0;
    if (stray_rv) begin
      vrf_data.data_rvalid = 1'b1;
      vrf_data.data_rdata  = 32'hBAD0_0000;
    end else if (pend.size() > 0 && pend[0].due <= cyc && cyc >= rv_block_until) begin
      vrf_data.data_rvalid = 1'b1;
      vrf_data.data_rdata  = pend[0].addr;
      vrf_data.data_err    = (rsp_cnt == err_idx);
    end
    #1;
    req_at[cyc]  = vrf_data.data_req;
    addr_at[cyc] = vrf_data.data_addr;
    err_at[cyc]  = err_o;
    busy_at[cyc] = busy_o;
    if (done_o) done_cyc.push_back(32'(cyc));
    if (st_ready_o) begin st_ready_cnt++; st_cnt++; end
    st_hold = st_valid_i && !st_ready_o;
    if (ld_valid_o) begin
      ld_data_q.push_back(ld_data_o);
      ld_idx_q.push_back(32'(ld_idx_o));
    end
    if (vrf_data.data_rvalid && !stray_rv) begin
      rv_cyc.push_back(32'(cyc));
      void'(pend.pop_front());
      rsp_cnt++;
    end
    if (vrf_data.data_req && vrf_data.data_gnt) begin
      hs_addr.push_back(vrf_data.data_addr);
      hs_cyc.push_back(32'(cyc));
      hs_we.push_back(32'(vrf_data.data_we));
      hs_wdata.push_back(vrf_data.data_wdata);
      pend.push_back('{vrf_data.data_addr, cyc + 1});
    end
  endtask

  task automatic do_start(input bit st, input logic [31:0] base, input logic [31:0] stride,
                          input logic [7:0] num, output int s);
    is_store_i  = st;
    base_addr_i = base;
    stride_i    = stride;
    num_words_i = num;
    start_req   = 1;
    step();
    s = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cyc.size() == 0 && n < 60) begin
      step();
      n++;
    end
    check({tag, " done seen"}, 32'(done_cyc.size()), 32'd1);
  endtask

  initial begin
    int s;
    rst_ni = 1'b0;
    start_i = 0; is_store_i = 0; base_addr_i = 0; stride_i = 0; num_words_i = 0;
    st_valid_i = 0; st_data_i = 0;
    vrf_data.data_gnt = 0; vrf_data.data_rvalid = 0;
    vrf_data.data_rdata = 0; vrf_data.data_err = 0;
    @(negedge clk_i); @(negedge clk_i); #1;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst req", 32'(vrf_data.data_req), 32'd0);
    check("rst we", 32'(vrf_data.data_we), 32'd0);
    check("rst be", 32'(vrf_data.data_be), 32'hF);
    check("rst addr", vrf_data.data_addr, 32'h0);
    check("rst ld_valid", 32'(ld_valid_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // Load, stride 4, back-to-back grants, 1-cycle response latency.
    clear_logs();
    do_start(0, 32'h1000, 32'd4, 8'd4, s);
    wait_done("t1");
    repeat (3) step();
    check("t1 n_req", 32'(hs_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1 addr%0d", i), qget(hs_addr, i), 32'h1000 + 32'(4 * i));
      check($sformatf("t1 reqcyc%0d", i), qget(hs_cyc, i), 32'(s + 1 + i));
      check($sformatf("t1 idx%0d", i), qget(ld_idx_q, i), 32'(i));
      check($sformatf("t1 data%0d", i), qget(ld_data_q, i), 32'h1000 + 32'(4 * i));
    end
    check("t1 done count", 32'(done_cyc.size()), 32'd1);
    check("t1 done cyc", qget(done_cyc, 0), 32'(s + 6));
    check("t1 done after rv", qget(done_cyc, 0), qget(rv_cyc, 3) + 32'd1);
    check("t1 busy at done", 32'(busy_at[s + 6]), 32'd0);

    // Store with negative stride wrapping below zero.
    clear_logs();
    st_mode = 1;
    do_start(1, 32'h4, 32'hFFFF_FFF8, 8'd3, s);
    wait_done("t2");
    repeat (2) step();
    st_mode = 0;
    check("t2 addr0", qget(hs_addr, 0), 32'h0000_0004);
    check("t2 addr1", qget(hs_addr, 1), 32'hFFFF_FFFC);
    check("t2 addr2", qget(hs_addr, 2), 32'hFFFF_FFF4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2 we%0d", i), qget(hs_we, i), 32'd1);
      check($sformatf("t2 wdata%0d", i), qget(hs_wdata, i), 32'hD000_0000 + 32'(i));
    end
    check("t2 st_ready count", 32'(st_ready_cnt), 32'd3);
    check("t2 no ld_valid", 32'(ld_data_q.size()), 32'd0);

    // Outstanding limit with responses withheld for 5 cycles.
    clear_logs();
    rv_block_until = cyc + 7;
    do_start(0, 32'h2000, 32'd4, 8'd4, s);
    wait_done("t3");
    rv_block_until = 0;
    check("t3 req s+3", 32'(req_at[s + 3]), 32'd0);
    check("t3 req s+5", 32'(req_at[s + 5]), 32'd0);
    check("t3 first rv", qget(rv_cyc, 0), 32'(s + 6));
    check("t3 req at rv", 32'(req_at[s + 6]), 32'd0);
    check("t3 hs0", qget(hs_cyc, 0), 32'(s + 1));
    check("t3 hs1", qget(hs_cyc, 1), 32'(s + 2));
    check("t3 hs2 resume", qget(hs_cyc, 2), 32'(s + 7));
    check("t3 rv with gnt", qget(rv_cyc, 1), 32'(s + 7));
    check("t3 req after gnt+rv", 32'(req_at[s + 8]), 32'd1);
    check("t3 hs3", qget(hs_cyc, 3), 32'(s + 8));
    check("t3 done cyc", qget(done_cyc, 0), 32'(s + 10));
    check("t3 idx3", qget(ld_idx_q, 3), 32'd3);

    // Grant withheld for 3 cycles: request must hold steady.
    clear_logs();
    gnt_low_until = cyc + 5;
    do_start(0, 32'h3000, 32'h10, 8'd2, s);
    wait_done("t4");
    gnt_low_until = 0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("t4 req s+%0d", k), 32'(req_at[s + k]), 32'd1);
      check($sformatf("t4 addr s+%0d", k), addr_at[s + k], 32'h3000);
    end
    check("t4 hs0", qget(hs_cyc, 0), 32'(s + 4));
    check("t4 hs1", qget(hs_cyc, 1), 32'(s + 5));
    check("t4 addr1", qget(hs_addr, 1), 32'h3010);

    // Error on element 1 of 3 is sticky through done.
    clear_logs();
    err_idx = 1;
    do_start(0, 32'h6000, 32'd4, 8'd3, s);
    wait_done("t5");
    err_idx = -1;
    check("t5 err before", 32'(err_at[s + 3]), 32'd0);
    check("t5 err after", 32'(err_at[s + 4]), 32'd1);
    check("t5 done cyc", qget(done_cyc, 0), 32'(s + 5));
    check("t5 err at done", 32'(err_at[s + 5]), 32'd1);
    step();
    check("t5 err sticky", 32'(err_o), 32'd1);

    // Zero-length command: immediate done, no requests, error cleared.
    clear_logs();
    do_start(0, 32'h7000, 32'd4, 8'd0, s);
    repeat (3) step();
    check("t6 done cyc", qget(done_cyc, 0), 32'(s + 1));
    check("t6 done count", 32'(done_cyc.size()), 32'd1);
    check("t6 err cleared", 32'(err_at[s + 1]), 32'd0);
    check("t6 no req", 32'(hs_addr.size()), 32'd0);
    check("t6 req s+1", 32'(req_at[s + 1]), 32'd0);
    check("t6 busy", 32'(busy_at[s + 1]), 32'd0);

    // Reset while draining, then a stray response.
    clear_logs();
    rv_block_until = cyc + 1000;
    do_start(0, 32'h5000, 32'd4, 8'd2, s);
    repeat (3) step();
    check("t7 busy drain", 32'(busy_at[s + 3]), 32'd1);
    check("t7 req drain", 32'(req_at[s + 3]), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("t7 rst busy", 32'(busy_o), 32'd0);
    check("t7 rst req", 32'(vrf_data.data_req), 32'd0);
    check("t7 rst addr", vrf_data.data_addr, 32'h0);
    check("t7 rst we", 32'(vrf_data.data_we), 32'd0);
    check("t7 rst done", 32'(done_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pend.delete();
    rv_block_until = 0;
    stray_rv = 1;
    step();
    check("t7 stray ld_valid", 32'(ld_valid_o), 32'd0);
    check("t7 stray ld_data", ld_data_o, 32'h0);
    check("t7 stray ld_idx", 32'(ld_idx_o), 32'd0);
    stray_rv = 0;
    step();
    check("t7 post busy", 32'(busy_o), 32'd0);
    check("t7 post done", 32'(done_o), 32'd0);
    check("t7 post err", 32'(err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
